mesh_timestep_controller: RTL and testbench



---
 rtl/mesh_ctrl_pkg.sv | 22 ++
 rtl/mesh_done_tracker.sv | 30 +++
 rtl/mesh_timestep_controller.sv | 166 ++++++++++++++++
 tb/tb_mesh_timestep_controller.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mesh_ctrl_pkg.sv
// Shared definitions for the mesh timestep sequencer: state encoding and
// default drain / watchdog limits.
package mesh_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_ADVANCE = 3'd4,
        ST_FINISH  = 3'd5
    } state_e;

    localparam int DEF_DRAIN_CYCLES   = 8;
    localparam int DEF_TIMEOUT_CYCLES = 4096;

    // Bits needed to hold values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mesh_done_tracker.sv
// Sticky per-node completion mask; all_done also sees this cycle's node_done
// so a completion arriving in the same cycle is not delayed.
module mesh_done_tracker #(
    parameter int NUM_NODES = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clear,
    input  logic                 i_accum,
    input  logic [NUM_NODES-1:0] i_node_done,
    output logic                 o_all_done
);

    logic [NUM_NODES-1:0] r_mask;
    logic [NUM_NODES-1:0] w_merged;

    assign w_merged   = r_mask | i_node_done;
    assign o_all_done = &w_merged;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mask <= '0;
        end else if (i_clear) begin
            r_mask <= '0;
        end else if (i_accum) begin
            r_mask <= w_merged;
        end
    end

endmodule

// File: rtl/mesh_timestep_controller.sv
// Global SNN timestep sequencer: broadcasts step_start, gathers node dones,
// waits for a quiet NoC window, then advances until the run completes.
//   state   | meaning
//   IDLE    | no run; waiting for start
//   START   | step_start broadcast, mask and watchdog cleared
//   COMPUTE | accumulating node_done until every node reports
//   DRAIN   | waiting for DRAIN_CYCLES consecutive noc_idle
//   ADVANCE | bump timestep or finish on the last one
//   FINISH  | one-cycle done pulse
module mesh_timestep_controller
    import mesh_ctrl_pkg::*;
#(
    parameter  int ROWS           = 2,
    parameter  int COLS           = 2,
    parameter  int TS_WIDTH       = 16,
    parameter  int DRAIN_CYCLES   = DEF_DRAIN_CYCLES,
    parameter  int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int NUM_NODES      = ROWS * COLS
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [TS_WIDTH-1:0]  i_num_timesteps,
    input  logic                 i_abort,
    input  logic [NUM_NODES-1:0] i_node_done,
    input  logic                 i_noc_idle,
    output logic                 o_step_start,
    output logic [TS_WIDTH-1:0]  o_timestep,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_timeout_err
);

    localparam int DW = cnt_width(DRAIN_CYCLES);
    localparam int WW = cnt_width(TIMEOUT_CYCLES);

    state_e               r_state;
    state_e               w_next;
    logic                 r_step_start;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_timeout_err;
    logic [TS_WIDTH-1:0]  r_timestep;
    logic [TS_WIDTH-1:0]  r_last;
    logic [DW-1:0]        r_drain_cnt;
    logic [WW-1:0]        r_wd_cnt;

    logic                 w_all_done;
    logic                 w_drain_hit;
    logic                 w_wd_hit;
    logic                 w_is_last;
    logic                 w_in_wd;
    logic                 w_step_start_nxt;
    logic                 w_busy_nxt;
    logic                 w_done_nxt;

    assign w_drain_hit = i_noc_idle && (r_drain_cnt == DW'(DRAIN_CYCLES - 1));
    assign w_wd_hit    = (r_wd_cnt == WW'(TIMEOUT_CYCLES - 1));
    assign w_is_last   = (r_timestep == r_last);
    assign w_in_wd     = (r_state == ST_COMPUTE) || (r_state == ST_DRAIN);

    mesh_done_tracker #(
        .NUM_NODES (NUM_NODES)
    ) u_done_tracker (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clear     (r_state == ST_START),
        .i_accum     (r_state == ST_COMPUTE),
        .i_node_done (i_node_done),
        .o_all_done  (w_all_done)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_step_start <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_step_start <= w_step_start_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
        end
    end

    // Abort overrides everything outside IDLE; watchdog beats normal progress.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_next = (i_num_timesteps != '0) ? ST_START : ST_FINISH;
                end
            end
            ST_START:   w_next = ST_COMPUTE;
            ST_COMPUTE: begin
                if (w_wd_hit) begin
                    w_next = ST_FINISH;
                end else if (w_all_done) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_wd_hit) begin
                    w_next = ST_FINISH;
                end else if (w_drain_hit) begin
                    w_next = ST_ADVANCE;
                end
            end
            ST_ADVANCE: w_next = w_is_last ? ST_FINISH : ST_START;
            ST_FINISH:  w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
        if (i_abort && (r_state != ST_IDLE)) begin
            w_next = ST_IDLE;
        end
    end

    always_comb begin
        w_step_start_nxt = (w_next == ST_START);
        w_busy_nxt       = (w_next != ST_IDLE);
        w_done_nxt       = (w_next == ST_FINISH);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_drain_cnt   <= '0;
            r_wd_cnt      <= '0;
            r_timestep    <= '0;
            r_last        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == ST_DRAIN) begin
                r_drain_cnt <= i_noc_idle ? (r_drain_cnt + DW'(1)) : '0;
            end else begin
                r_drain_cnt <= '0;
            end

            r_wd_cnt <= w_in_wd ? (r_wd_cnt + WW'(1)) : '0;

            if ((r_state == ST_IDLE) && i_start) begin
                r_timeout_err <= 1'b0;
                if (i_num_timesteps != '0) begin
                    r_last     <= i_num_timesteps - TS_WIDTH'(1);
                    r_timestep <= '0;
                end
            end

            if ((r_state == ST_ADVANCE) && !i_abort && !w_is_last) begin
                r_timestep <= r_timestep + TS_WIDTH'(1);
            end

            if (w_in_wd && !i_abort && w_wd_hit) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign o_step_start  = r_step_start;
    assign o_timestep    = r_timestep;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mesh_timestep_controller.sv
// Randomized scoreboard bench: a per-run plan model predicts the cycle of every
// step_start / done pulse and side checks, and a monitor compares them.
module tb_mesh_timestep_controller;

    localparam int D     = 4;
    localparam int T     = 64;
    localparam int MAXC  = 8000;
    localparam int NEVER = 100000;

    localparam int K_STEP = 0;
    localparam int K_DONE = 1;
    localparam int K_IDLE = 2;
    localparam int K_RST  = 3;
    localparam int K_BLOW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] num;
    logic        abort;
    logic [3:0]  node_done;
    logic        noc_idle;
    logic        o_step_start;
    logic [15:0] o_timestep;
    logic        o_busy;
    logic        o_done;
    logic        o_timeout_err;

    mesh_timestep_controller #(
        .ROWS           (2),
        .COLS           (2),
        .TS_WIDTH       (16),
        .DRAIN_CYCLES   (D),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_start         (start),
        .i_num_timesteps (num),
        .i_abort         (abort),
        .i_node_done     (node_done),
        .i_noc_idle      (noc_idle),
        .o_step_start    (o_step_start),
        .o_timestep      (o_timestep),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_timeout_err   (o_timeout_err)
    );

    always #5 clk = ~clk;

    bit        s_rst   [MAXC];
    bit        s_start [MAXC];
    bit        s_abort [MAXC];
    bit        s_idle  [MAXC];
    bit [3:0]  s_done  [MAXC];
    bit [15:0] s_num   [MAXC];

    typedef struct {
        int cyc;
        int kind;
        int ts;
        bit terr;
    } ev_t;

    ev_t evq[$];
    int  cyc = 0;
    int  n_checks = 0;
    int  n_errors = 0;
    int  sched_hi = 0;
    int  cur_ts = 0;
    bit  cur_terr = 0;
    bit  gen_ready = 0;
    int  end_cyc = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic push_ev(input int c, input int k, input int ts, input bit te);
        ev_t e;
        e.cyc = c; e.kind = k; e.ts = ts; e.terr = te;
        evq.push_back(e);
    endtask

    task automatic mark(input int c);
        if (c > sched_hi) sched_hi = c;
    endtask

    task automatic finish_run(input int f, input int ts, input bit te, output int nxt);
        push_ev(f, K_DONE, ts, te);
        push_ev(f + 1, K_BLOW, 0, 0);
        cur_terr = te;
        nxt = (f + 1 > sched_hi + 1) ? f + 1 : sched_hi + 1;
    endtask

    // off_mode: 0 random 0..8, 1 all at 5, 2 four distinct cycles
    // idle_mode: 0 always idle, 1 random, 2 pattern 1,1,1,0 then idle
    task automatic gen_run(input int s, input int n, input bit level, input int off_mode,
                           input int idle_mode, input int stuck, input int abort_ts,
                           input int rst_ts, output int nxt);
        int t, c0, call, d0, e, run, hold_end, rot, mx, x;
        bit v;
        int off[4];
        int pat[8];
        pat = '{1, 1, 1, 0, 1, 1, 1, 1};
        s_start[s] = 1'b1;
        s_num[s]   = 16'(n);
        mark(s);
        cur_terr = 1'b0;
        if (n == 0) begin
            finish_run(s + 1, cur_ts, 1'b0, nxt);
            return;
        end
        t = s + 1;
        for (int ts = 0; ts < n; ts++) begin
            cur_ts = ts;
            push_ev(t, K_STEP, ts, 1'b0);
            s_done[t] |= 4'($urandom);
            mark(t);
            c0  = t + 1;
            rot = $urandom_range(0, 3);
            mx  = 0;
            for (int i = 0; i < 4; i++) begin
                if (off_mode == 0)      off[i] = $urandom_range(0, 8);
                else if (off_mode == 1) off[i] = 5;
                else                    off[i] = (i + rot) % 4;
                if (ts == 0 && stuck == i) off[i] = NEVER;
                if (off[i] > mx) mx = off[i];
            end
            call     = c0 + mx;
            hold_end = (call < c0 + T - 1) ? call : c0 + T - 1;
            for (int i = 0; i < 4; i++) begin
                if (off[i] != NEVER) begin
                    if (level) begin
                        for (int c = c0 + off[i]; c <= hold_end; c++) begin
                            s_done[c][i] = 1'b1;
                            mark(c);
                        end
                    end else begin
                        s_done[c0 + off[i]][i] = 1'b1;
                        mark(c0 + off[i]);
                    end
                end
            end
            for (int c = c0; c <= hold_end; c++) begin
                s_idle[c] = 1'($urandom_range(0, 1));
                mark(c);
            end
            if (rst_ts == ts) begin
                x = c0 + 1;
                s_rst[x] = 1'b1;
                mark(x);
                push_ev(x + 1, K_RST, 0, 0);
                cur_ts   = 0;
                cur_terr = 1'b0;
                nxt = (x + 2 > sched_hi + 1) ? x + 2 : sched_hi + 1;
                return;
            end
            if (call >= c0 + T - 1) begin
                finish_run(c0 + T, ts, 1'b1, nxt);
                return;
            end
            d0  = call + 1;
            run = 0;
            e   = -1;
            for (int c = d0; e < 0; c++) begin
                if (idle_mode == 0)      v = 1'b1;
                else if (idle_mode == 1) v = (c - d0 >= 10) ? 1'b1 : ($urandom_range(0, 3) != 0);
                else                     v = (c - d0 < 8) ? pat[c - d0][0] : 1'b1;
                s_idle[c] = v;
                mark(c);
                run = v ? run + 1 : 0;
                if (run == D) e = c;
            end
            if (abort_ts == ts) begin
                x = d0 + 1;
                s_abort[x] = 1'b1;
                mark(x);
                push_ev(x + 1, K_IDLE, ts, cur_terr);
                nxt = (x + 2 > sched_hi + 1) ? x + 2 : sched_hi + 1;
                return;
            end
            if (e >= c0 + T - 1) begin
                finish_run(c0 + T, ts, 1'b1, nxt);
                return;
            end
            if (ts == n - 1) begin
                finish_run(e + 2, ts, 1'b0, nxt);
                return;
            end
            t = e + 2;
        end
        nxt = sched_hi + 1;
    endtask

    task automatic drive(input int c);
        if (c < MAXC) begin
            rst = s_rst[c]; start = s_start[c]; num = s_num[c];
            abort = s_abort[c]; node_done = s_done[c]; noc_idle = s_idle[c];
        end else begin
            rst = 1'b0; start = 1'b0; num = '0; abort = 1'b0; node_done = '0; noc_idle = 1'b0;
        end
    endtask

    ev_t mev;
    bit  exp_step;
    bit  exp_done;

    always @(negedge clk) begin
        if (gen_ready && cyc >= 2) begin
            exp_step = 1'b0;
            exp_done = 1'b0;
            while (evq.size() > 0 && evq[0].cyc <= cyc) begin
                mev = evq.pop_front();
                if (mev.cyc < cyc) check("event_cycle", cyc, mev.cyc);
                case (mev.kind)
                    K_STEP: begin
                        exp_step = 1'b1;
                        check("step_timestep", o_timestep, mev.ts);
                        check("step_timeout_err", o_timeout_err, mev.terr);
                    end
                    K_DONE: begin
                        exp_done = 1'b1;
                        check("done_timestep", o_timestep, mev.ts);
                        check("done_timeout_err", o_timeout_err, mev.terr);
                    end
                    K_IDLE: begin
                        check("abort_busy", o_busy, 0);
                        check("abort_timestep", o_timestep, mev.ts);
                        check("abort_timeout_err", o_timeout_err, mev.terr);
                    end
                    K_RST: begin
                        check("rst_step_start", o_step_start, 0);
                        check("rst_timestep", o_timestep, 0);
                        check("rst_busy", o_busy, 0);
                        check("rst_done", o_done, 0);
                        check("rst_timeout_err", o_timeout_err, 0);
                    end
                    default: check("busy_after_done", o_busy, 0);
                endcase
            end
            if (exp_step || o_step_start === 1'b1) check("step_start", o_step_start, exp_step);
            if (exp_done || o_done === 1'b1)       check("done", o_done, exp_done);
        end
    end

    initial begin
        int s, nxt, n, stk;
        s_rst[0] = 1'b1; s_rst[1] = 1'b1; s_rst[2] = 1'b1;
        push_ev(3, K_RST, 0, 0);
        sched_hi = 3;

        gen_run(5, 3, 1'b0, 1, 0, -1, -1, -1, nxt);
        gen_run(nxt + 1, 1, 1'b0, 2, 0, -1, -1, -1, nxt);
        gen_run(nxt + 2, 1, 1'b1, 2, 0, -1, -1, -1, nxt);
        gen_run(nxt + 1, 2, 1'b0, 0, 2, -1, -1, -1, nxt);
        gen_run(nxt + 1, 2, 1'b0, 1, 0, 2, -1, -1, nxt);
        gen_run(nxt + 1, 1, 1'b1, 0, 1, -1, -1, -1, nxt);
        s = nxt + 1;
        s_start[s + 3] = 1'b1;
        s_num[s + 3]   = 16'd7;
        gen_run(s, 5, 1'b0, 0, 1, -1, 2, -1, nxt);
        s = nxt + 1;
        s_abort[s] = 1'b1;
        gen_run(s, 0, 1'b0, 0, 0, -1, -1, -1, nxt);
        gen_run(nxt + 1, 2, 1'b0, 1, 0, -1, -1, 1, nxt);

        for (int i = 0; i < 14; i++) begin
            if (nxt < MAXC - 400) begin
                if ($urandom_range(0, 2) == 0) begin
                    s_abort[nxt] = 1'b1;
                    mark(nxt);
                end
                s   = nxt + 1 + $urandom_range(0, 2);
                n   = $urandom_range(0, 4);
                stk = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : -1;
                gen_run(s, n, 1'($urandom_range(0, 1)), $urandom_range(0, 1) * 2, 1, stk, -1, -1, nxt);
            end
        end
        end_cyc = nxt;

        drive(0);
        gen_ready = 1'b1;
        fork
            forever begin
                @(posedge clk);
                cyc = cyc + 1;
                #1;
                drive(cyc);
            end
        join_none

        wait (cyc >= end_cyc + 4);
        @(negedge clk);
        #1;
        check("events_pending", evq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
